cond_flags: RTL and testbench
=============================

Name: cond_flags

Overview:
- Architectural NZCV flag register and condition evaluator for the ARM-style core; it sits on the consuming end of the ALU flag interface.
- Captures the ALU's 4-bit `nzcv` result when the instruction sets flags, supports MSR-style direct writes and exception save/restore of the flags.
- Drives the held C and V back to the ALU as `cin`/`vin`.
- Evaluates the 4-bit condition field of the instruction in execute to produce its pass/fail decision.

Parameters:
- BYPASS, 1: 1 = condition evaluated against the flags being written this cycle (same-cycle forward); 0 = against the registered flags only.

Ports:
- clk        input   1  system clock, rising edge
- rst_n      input   1  asynchronous active-low reset
- alu_nzcv   input   4  flags from ALU: [3]=N [2]=Z [1]=C [0]=V
- flag_we    input   1  commit alu_nzcv to flags (S-bit instruction retiring)
- msr_we     input   1  direct flag write
- msr_data   input   4  flags value for msr_we
- save       input   1  copy current flags into saved register (exception entry)
- restore    input   1  copy saved register into flags (exception return)
- cond       input   4  condition field of the instruction in execute
- nzcv       output  4  registered architectural flags
- cin        output  1  equals nzcv[1]; feeds ALU carry-in
- vin        output  1  equals nzcv[0]; feeds ALU overflow pass-through
- cond_pass  output  1  condition result (combinational)
- saved_nzcv output  4  registered saved flags
- saved_vld  output  1  saved register holds valid data
- restore_err output 1  one-cycle pulse: restore requested with saved_vld=0

Behaviour:
- Reset (async, rst_n low):
  - nzcv=0000, saved_nzcv=0000, saved_vld=0, restore_err=0.
  - Outputs take these values immediately on assertion, independent of clk.
- Flag next-state (nzcv_next), priority high to low, registered on rising clk:
  - restore with saved_vld=1 -> saved_nzcv.
  - msr_we -> msr_data.
  - flag_we -> alu_nzcv.
  - otherwise hold.
- Restore with saved_vld=0:
  - Flags follow the next-lower-priority source: msr_we, then flag_we, else hold.
  - restore_err=1 for exactly the following cycle.
  - restore_err is otherwise 0.
- Save:
  - saved_nzcv <= current registered nzcv (pre-update value, even if a flag write lands the same cycle).
  - saved_vld <= 1.
- Restore with saved_vld=1:
  - saved_vld <= 0.
  - If save is asserted in the same cycle, save wins: saved_nzcv <= nzcv, saved_vld stays 1, and flags still load the old saved_nzcv (swap).
- cin/vin: always the registered nzcv[1]/nzcv[0]; never bypassed.
- Flags for condition evaluation (F): nzcv_next when BYPASS=1, nzcv when BYPASS=0.
- cond_pass from F:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Latency:
  - Flag write is visible on nzcv/cin/vin one cycle after the write strobe.
  - With BYPASS=1 it is visible on cond_pass in the same cycle.
- No X propagation: all strobes are qualified; an unused alu_nzcv/msr_data has no effect.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 mid-run with nzcv=1111 and saved_vld=1.
  - Required: nzcv=0000, saved_vld=0 and restore_err=0 without a clock edge; cond=0001 (NE) -> cond_pass=1; cond=1111 -> cond_pass=0.
- Flag write and bypass:
  - Stimulus: flag_we=1, alu_nzcv=0100, cond=0000.
  - Required (BYPASS=1): cond_pass=1 in the same cycle; next cycle nzcv=0100, cin=0, vin=0.
  - Required (BYPASS=0): cond_pass=0 in the same cycle (flags 0000), 1 the following cycle.
- Priority:
  - Stimulus: flag_we=1 alu_nzcv=1111 together with msr_we=1 msr_data=0010.
  - Required: nzcv=0010, cin=1; cond=1000 (HI) -> cond_pass=1.
- Save/restore:
  - Stimulus: nzcv=1001, save; then msr_we 0000; then restore.
  - Required: saved_nzcv=1001 and saved_vld=1; after restore nzcv=1001 and saved_vld=0; a second restore gives restore_err pulse=1 for one cycle with nzcv unchanged.
- Swap:
  - Stimulus: saved_nzcv=0011 valid, nzcv=1100, save+restore in the same cycle.
  - Required: nzcv=0011, saved_nzcv=1100, saved_vld=1.
- Condition sweep:
  - Stimulus: for each of the 16 values of nzcv, all 16 cond codes.
  - Required: cond_pass matches the table, e.g. nzcv=1000 -> GE=0, LT=1, LE=1; nzcv=1001 -> GE=1, GT=1.

Source files
------------

// File: rtl/cond_flags_if.sv
// Flag/condition interface between the ALU/issue side (master) and the
// architectural NZCV flag register (slave).
interface cond_flags_if;
   logic [3:0] alu_nzcv;
   logic       flag_we;
   logic       msr_we;
   logic [3:0] msr_data;
   logic       save;
   logic       restore;
   logic [3:0] cond;
   logic [3:0] nzcv;
   logic       cin;
   logic       vin;
   logic       cond_pass;
   logic [3:0] saved_nzcv;
   logic       saved_vld;
   logic       restore_err;

   modport master (
      output alu_nzcv, flag_we, msr_we, msr_data, save, restore, cond,
      input  nzcv, cin, vin, cond_pass, saved_nzcv, saved_vld, restore_err
   );

   modport slave (
      input  alu_nzcv, flag_we, msr_we, msr_data, save, restore, cond,
      output nzcv, cin, vin, cond_pass, saved_nzcv, saved_vld, restore_err
   );
endinterface

// File: rtl/cond_flags.sv
// Architectural NZCV flag register with exception save/restore slot and
// ARM-style condition-code evaluator.
module cond_flags #(
   parameter bit BYPASS = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   cond_flags_if.slave io_bus
);

   logic [3:0] r_nzcv;
   logic [3:0] r_saved_nzcv;
   logic       r_saved_vld;
   logic       r_restore_err;

   logic       w_restore_ok;
   logic [3:0] w_nzcv_next;
   logic [3:0] w_flags;
   logic       w_n, w_z, w_c, w_v;
   logic       w_pass;

   assign w_restore_ok = io_bus.restore & r_saved_vld;

   always_comb begin
      w_nzcv_next = r_nzcv;
      if (w_restore_ok) begin
         w_nzcv_next = r_saved_nzcv;
      end else if (io_bus.msr_we) begin
         w_nzcv_next = io_bus.msr_data;
      end else if (io_bus.flag_we) begin
         w_nzcv_next = io_bus.alu_nzcv;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nzcv        <= 4'b0000;
         r_saved_nzcv  <= 4'b0000;
         r_saved_vld   <= 1'b0;
         r_restore_err <= 1'b0;
      end else begin
         r_nzcv        <= w_nzcv_next;
         r_restore_err <= io_bus.restore & ~r_saved_vld;
         // Save takes precedence over the valid-clear of a restore, giving a swap.
         if (io_bus.save) begin
            r_saved_nzcv <= r_nzcv;
            r_saved_vld  <= 1'b1;
         end else if (w_restore_ok) begin
            r_saved_vld  <= 1'b0;
         end
      end
   end

   assign w_flags = BYPASS ? w_nzcv_next : r_nzcv;
   assign w_n     = w_flags[3];
   assign w_z     = w_flags[2];
   assign w_c     = w_flags[1];
   assign w_v     = w_flags[0];

   always_comb begin
      w_pass = 1'b0;
      case (io_bus.cond)
         4'b0000: w_pass = w_z;
         4'b0001: w_pass = ~w_z;
         4'b0010: w_pass = w_c;
         4'b0011: w_pass = ~w_c;
         4'b0100: w_pass = w_n;
         4'b0101: w_pass = ~w_n;
         4'b0110: w_pass = w_v;
         4'b0111: w_pass = ~w_v;
         4'b1000: w_pass = w_c & ~w_z;
         4'b1001: w_pass = ~w_c | w_z;
         4'b1010: w_pass = (w_n == w_v);
         4'b1011: w_pass = (w_n != w_v);
         4'b1100: w_pass = ~w_z & (w_n == w_v);
         4'b1101: w_pass = w_z | (w_n != w_v);
         4'b1110: w_pass = 1'b1;
         default: w_pass = 1'b0;
      endcase
   end

   assign io_bus.nzcv        = r_nzcv;
   assign io_bus.cin         = r_nzcv[1];
   assign io_bus.vin         = r_nzcv[0];
   assign io_bus.cond_pass   = w_pass;
   assign io_bus.saved_nzcv  = r_saved_nzcv;
   assign io_bus.saved_vld   = r_saved_vld;
   assign io_bus.restore_err = r_restore_err;

endmodule

// File: tb/tb_cond_flags.sv
// Bench for cond_flags: BYPASS=1 and BYPASS=0 instances share one stimulus
// stream and are checked against a behavioural flag/condition model.
module tb_cond_flags;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] d_alu = '0, d_md = '0, d_cond = '0;
   logic       d_fwe = 0, d_msr = 0, d_save = 0, d_rest = 0;

   cond_flags_if if1 ();
   cond_flags_if if0 ();

   assign if1.alu_nzcv = d_alu;  assign if0.alu_nzcv = d_alu;
   assign if1.flag_we  = d_fwe;  assign if0.flag_we  = d_fwe;
   assign if1.msr_we   = d_msr;  assign if0.msr_we   = d_msr;
   assign if1.msr_data = d_md;   assign if0.msr_data = d_md;
   assign if1.save     = d_save; assign if0.save     = d_save;
   assign if1.restore  = d_rest; assign if0.restore  = d_rest;
   assign if1.cond     = d_cond; assign if0.cond     = d_cond;

   cond_flags #(.BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .io_bus(if1.slave));
   cond_flags #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .io_bus(if0.slave));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   logic [3:0] m_nzcv = '0, m_saved = '0;
   logic       m_vld = 0, m_err = 0;

   typedef struct {
      logic [3:0] flags;
      logic [3:0] cond;
      logic       pass;
   } vec_t;

   // Condition pairs share a base predicate; odd codes invert it.
   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v, base;
      n = f[3]; z = f[2]; cc = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cc;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cc && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   function automatic logic [3:0] model_next();
      if (d_rest && m_vld) return m_saved;
      if (d_msr)           return d_md;
      if (d_fwe)           return d_alu;
      return m_nzcv;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("nzcv",        if1.nzcv, m_nzcv);
      chk("nzcv_nb",     if0.nzcv, m_nzcv);
      chk("cin",         {3'b0, if1.cin}, {3'b0, m_nzcv[1]});
      chk("vin",         {3'b0, if1.vin}, {3'b0, m_nzcv[0]});
      chk("saved_nzcv",  if1.saved_nzcv, m_saved);
      chk("saved_vld",   {3'b0, if1.saved_vld}, {3'b0, m_vld});
      chk("restore_err", {3'b0, if1.restore_err}, {3'b0, m_err});
      chk("pass_byp",    {3'b0, if1.cond_pass}, {3'b0, cond_eval(d_cond, model_next())});
      chk("pass_nobyp",  {3'b0, if0.cond_pass}, {3'b0, cond_eval(d_cond, m_nzcv)});
   endtask

   // Called at a negedge; inputs settle before the checks that follow.
   task automatic drive(input logic fwe, input logic [3:0] alu, input logic msr,
                        input logic [3:0] md, input logic sv, input logic rs,
                        input logic [3:0] cd);
      d_fwe = fwe; d_alu = alu; d_msr = msr; d_md = md;
      d_save = sv; d_rest = rs; d_cond = cd;
      #1;
   endtask

   task automatic tick();
      logic [3:0] nx;
      nx = model_next();
      @(posedge clk);
      m_err = d_rest && !m_vld;
      if (d_save) begin
         m_saved = m_nzcv;
         m_vld   = 1'b1;
      end else if (d_rest && m_vld) begin
         m_vld   = 1'b0;
      end
      m_nzcv = nx;
      @(negedge clk);
   endtask

   task automatic idle(input logic [3:0] cd);
      drive(0, 4'h0, 0, 4'h0, 0, 0, cd);
   endtask

   task automatic load(input logic [3:0] f);
      drive(0, 4'h0, 1, f, 0, 0, 4'h0);
      tick();
   endtask

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{4'b1000, 4'b1010, 1'b0};
      vecs[1]  = '{4'b1000, 4'b1011, 1'b1};
      vecs[2]  = '{4'b1000, 4'b1101, 1'b1};
      vecs[3]  = '{4'b1001, 4'b1010, 1'b1};
      vecs[4]  = '{4'b1001, 4'b1100, 1'b1};
      vecs[5]  = '{4'b0100, 4'b0000, 1'b1};
      vecs[6]  = '{4'b0000, 4'b0001, 1'b1};
      vecs[7]  = '{4'b0010, 4'b0010, 1'b1};
      vecs[8]  = '{4'b0010, 4'b1000, 1'b1};
      vecs[9]  = '{4'b0110, 4'b1000, 1'b0};
      vecs[10] = '{4'b0110, 4'b1001, 1'b1};
      vecs[11] = '{4'b1111, 4'b1111, 1'b0};
      vecs[12] = '{4'b0000, 4'b1110, 1'b1};
      vecs[13] = '{4'b1000, 4'b0101, 1'b0};

      @(negedge clk);
      idle(4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      idle(4'h0);
      check_all();

      // Flag write with same-cycle forward
      drive(1, 4'b0100, 0, 4'h0, 0, 0, 4'b0000);
      chk("wr_pass_byp",   {3'b0, if1.cond_pass}, 4'd1);
      chk("wr_pass_nobyp", {3'b0, if0.cond_pass}, 4'd0);
      tick();
      idle(4'b0000);
      chk("wr_nzcv", if1.nzcv, 4'b0100);
      chk("wr_cin",  {3'b0, if1.cin}, 4'd0);
      chk("wr_vin",  {3'b0, if1.vin}, 4'd0);
      chk("wr_pass_nobyp_next", {3'b0, if0.cond_pass}, 4'd1);
      check_all();

      // MSR beats ALU write
      drive(1, 4'b1111, 1, 4'b0010, 0, 0, 4'b1000);
      tick();
      idle(4'b1000);
      chk("pri_nzcv", if1.nzcv, 4'b0010);
      chk("pri_cin",  {3'b0, if1.cin}, 4'd1);
      chk("pri_hi",   {3'b0, if1.cond_pass}, 4'd1);

      // Save, overwrite, restore, then restore with nothing saved
      load(4'b1001);
      drive(0, 4'h0, 0, 4'h0, 1, 0, 4'h0);
      tick();
      drive(0, 4'h0, 1, 4'b0000, 0, 0, 4'h0);
      chk("sv_saved", if1.saved_nzcv, 4'b1001);
      chk("sv_vld",   {3'b0, if1.saved_vld}, 4'd1);
      tick();
      drive(0, 4'h0, 0, 4'h0, 0, 1, 4'h0);
      check_all();
      tick();
      idle(4'h0);
      chk("rs_nzcv", if1.nzcv, 4'b1001);
      chk("rs_vld",  {3'b0, if1.saved_vld}, 4'd0);
      drive(0, 4'h0, 0, 4'h0, 0, 1, 4'h0);
      tick();
      idle(4'h0);
      chk("rs2_err",  {3'b0, if1.restore_err}, 4'd1);
      chk("rs2_nzcv", if1.nzcv, 4'b1001);
      tick();
      idle(4'h0);
      chk("rs2_err_clr", {3'b0, if1.restore_err}, 4'd0);

      // Save and restore together swap flags with the saved slot
      load(4'b0011);
      drive(0, 4'h0, 0, 4'h0, 1, 0, 4'h0);
      tick();
      load(4'b1100);
      drive(0, 4'h0, 0, 4'h0, 1, 1, 4'h0);
      check_all();
      tick();
      idle(4'h0);
      chk("swap_nzcv",  if1.nzcv, 4'b0011);
      chk("swap_saved", if1.saved_nzcv, 4'b1100);
      chk("swap_vld",   {3'b0, if1.saved_vld}, 4'd1);

      // Hand-picked condition vectors
      foreach (vecs[i]) begin
         load(vecs[i].flags);
         idle(vecs[i].cond);
         chk($sformatf("vec%0d_byp", i),   {3'b0, if1.cond_pass}, {3'b0, vecs[i].pass});
         chk($sformatf("vec%0d_nobyp", i), {3'b0, if0.cond_pass}, {3'b0, vecs[i].pass});
      end

      // Full flag x condition sweep
      for (int f = 0; f < 16; f++) begin
         load(4'(f));
         for (int c = 0; c < 16; c++) begin
            idle(4'(c));
            check_all();
         end
      end

      // Random traffic against the model
      for (int k = 0; k < 2000; k++) begin
         drive(($urandom_range(0, 2) == 0), 4'($urandom), ($urandom_range(0, 4) == 0),
               4'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
               4'($urandom));
         check_all();
         tick();
      end

      // Asynchronous reset mid-cycle with live state
      load(4'b1111);
      drive(0, 4'h0, 0, 4'h0, 1, 0, 4'h0);
      tick();
      idle(4'b0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_nzcv",  if1.nzcv, 4'b0000);
      chk("rst_vld",   {3'b0, if1.saved_vld}, 4'd0);
      chk("rst_err",   {3'b0, if1.restore_err}, 4'd0);
      chk("rst_saved", if1.saved_nzcv, 4'b0000);
      chk("rst_ne",    {3'b0, if1.cond_pass}, 4'd1);
      chk("rst_ne_nb", {3'b0, if0.cond_pass}, 4'd1);
      d_cond = 4'b1111;
      #1;
      chk("rst_nv",    {3'b0, if1.cond_pass}, 4'd0);
      m_nzcv = '0; m_saved = '0; m_vld = 0; m_err = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 50; k++) begin
         drive(($urandom_range(0, 1) == 0), 4'($urandom), ($urandom_range(0, 3) == 0),
               4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               4'($urandom));
         check_all();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
